// File: rtl/exec_datapath.sv
// Execute/writeback stage: 8x16 register file, ALU and a shift-add multiplier.
// Latency: single-cycle ops complete at the accepting edge; MUL completes MUL_CYCLES edges after acceptance.
// Backpressure: stall is high while a multiply runs, and instructions offered during it are ignored.
module exec_datapath #(
  parameter int DATA_W     = 16,
  parameter int NREGS      = 8,
  parameter int MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              instr_valid,
  input  logic [3:0]        OPCODE,
  input  logic [2:0]        Rreg_Sig1,
  input  logic [2:0]        Rreg_Sig2,
  input  logic [2:0]        Wreg_Sig,
  input  logic [5:0]        Immediate_Addr,
  input  logic              Source2_select,
  input  logic              ALU_out_Select,
  input  logic              PC_select,
  output logic              stall,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NREGS];

  logic [DATA_W-1:0]   src1;
  logic [DATA_W-1:0]   src2;
  logic                accept;

  // ALU decode results
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_res_upd;   // result, flags, result_valid update
  logic                alu_flag_upd;  // flags update (superset of alu_res_upd, adds CMP)
  logic                alu_wb;
  logic                is_mul;

  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     shl_full;
  logic [DATA_W:0]     shr_full;
  logic [3:0]          sh;

  // Multiplier state
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [CW-1:0]       cnt;
  logic [2:0]          mul_rd;
  logic                mul_wb;
  logic                mul_done;

  // Register file write port
  logic                wr_en;
  logic [2:0]          wr_addr;
  logic [DATA_W-1:0]   wr_dat;

  assign src1     = regs[Rreg_Sig1];
  assign src2     = Source2_select ? {{(DATA_W-6){1'b0}}, Immediate_Addr} : regs[Rreg_Sig2];
  assign accept   = instr_valid && !stall;
  assign dbg_data = regs[dbg_addr];

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_done = (state == MUL_BUSY) && (cnt == '0);

  // Single-cycle ALU: operation result, carry and which state it is allowed to touch
  always_comb begin
    alu_res      = '0;
    alu_c        = 1'b0;
    alu_res_upd  = 1'b0;
    alu_flag_upd = 1'b0;
    alu_wb       = 1'b0;
    is_mul       = 1'b0;
    sh           = src2[3:0];
    sum          = {1'b0, src1} + {1'b0, src2};
    diff         = {1'b0, src1} - {1'b0, src2};
    // Shifting through one extra bit leaves the last bit shifted out in that bit
    shl_full     = {1'b0, src1} << sh;
    shr_full     = {src1, 1'b0} >> sh;
    if (!PC_select) begin
      alu_res_upd  = 1'b1;
      alu_flag_upd = 1'b1;
      case (OPCODE)
        4'd1:    begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
        4'd2:    begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
        4'd3:    alu_res = src1 & src2;
        4'd4:    alu_res = src1 | src2;
        4'd5:    alu_res = src1 ^ src2;
        4'd6:    alu_res = ~src1;
        4'd7:    begin alu_res = shl_full[DATA_W-1:0]; alu_c = shl_full[DATA_W]; end
        4'd8:    begin alu_res = shr_full[DATA_W:1];   alu_c = shr_full[0];      end
        4'd10:   begin
          alu_res     = diff[DATA_W-1:0];
          alu_c       = diff[DATA_W];
          alu_res_upd = 1'b0;
        end
        4'd11:   alu_res = src2;
        4'd9:    begin
          is_mul       = 1'b1;
          alu_res_upd  = 1'b0;
          alu_flag_upd = 1'b0;
        end
        default: begin
          alu_res_upd  = 1'b0;
          alu_flag_upd = 1'b0;
        end
      endcase
      alu_wb = alu_res_upd && ALU_out_Select;
    end
  end

  // Write port arbitration: the multiplier finishing and a new acceptance never coincide
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = Wreg_Sig;
    wr_dat  = alu_res;
    if (mul_done) begin
      wr_en   = mul_wb;
      wr_addr = mul_rd;
      wr_dat  = acc_next[DATA_W-1:0];
    end else if (accept) begin
      wr_en   = alu_wb;
    end
  end

  // Register file storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_dat;
    end
  end

  // Control FSM, multiplier iteration and registered result/flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      stall        <= 1'b0;
      cnt          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      mul_rd       <= '0;
      mul_wb       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      flag_n       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= {{DATA_W{1'b0}}, src1};
              mplier <= src2;
              acc    <= '0;
              cnt    <= CW'(MUL_CYCLES - 1);
              mul_rd <= Wreg_Sig;
              mul_wb <= ALU_out_Select;
              stall  <= 1'b1;
              state  <= MUL_BUSY;
            end else begin
              if (alu_flag_upd) begin
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
                flag_n <= alu_res[DATA_W-1];
              end
              if (alu_res_upd) begin
                result       <= alu_res;
                result_valid <= 1'b1;
              end
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state        <= IDLE;
            stall        <= 1'b0;
            result       <= acc_next[DATA_W-1:0];
            result_valid <= 1'b1;
            flag_z       <= (acc_next[DATA_W-1:0] == '0);
            flag_c       <= |acc_next[2*DATA_W-1:DATA_W];
            flag_n       <= acc_next[DATA_W-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_datapath.sv
// Bench for exec_datapath: directed scenarios followed by random instructions,
// each checked against an arithmetic reference model of registers, result and flags.
module tb_exec_datapath;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_valid;
  logic [3:0]  OPCODE;
  logic [2:0]  Rreg_Sig1, Rreg_Sig2, Wreg_Sig;
  logic [5:0]  Immediate_Addr;
  logic        Source2_select, ALU_out_Select, PC_select;
  logic        stall;
  logic [15:0] result;
  logic        result_valid;
  logic        flag_z, flag_c, flag_n;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #10 clk = ~clk;

  exec_datapath dut (
    .clk            (clk),
    .rstn           (rstn),
    .instr_valid    (instr_valid),
    .OPCODE         (OPCODE),
    .Rreg_Sig1      (Rreg_Sig1),
    .Rreg_Sig2      (Rreg_Sig2),
    .Wreg_Sig       (Wreg_Sig),
    .Immediate_Addr (Immediate_Addr),
    .Source2_select (Source2_select),
    .ALU_out_Select (ALU_out_Select),
    .PC_select      (PC_select),
    .stall          (stall),
    .result         (result),
    .result_valid   (result_valid),
    .flag_z         (flag_z),
    .flag_c         (flag_c),
    .flag_n         (flag_n),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data)
  );

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [5:0] imm;
    logic       s2;
    logic       osel;
    logic       pc;
  } ins_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [15:0] m_reg [8];
  logic [15:0] m_res;
  logic        m_z, m_c, m_n, m_rv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(input int op, input int rs1, input int rs2, input int rd,
                              input int imm, input int s2, input int osel, input int pc);
    ins_t i;
    i.op   = 4'(op);
    i.rs1  = 3'(rs1);
    i.rs2  = 3'(rs2);
    i.rd   = 3'(rd);
    i.imm  = 6'(imm);
    i.s2   = 1'(s2);
    i.osel = 1'(osel);
    i.pc   = 1'(pc);
    return i;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_reg[r] = 16'h0;
    m_res = 16'h0;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_rv = 1'b0;
  endtask

  // Architectural effect of one instruction, written as plain integer arithmetic
  task automatic model_apply(input ins_t i);
    int unsigned     a, b, r, sh;
    longint unsigned p;
    bit              c;
    m_rv = 1'b0;
    a = 32'(m_reg[i.rs1]);
    b = i.s2 ? 32'(i.imm) : 32'(m_reg[i.rs2]);
    sh = b % 16;
    r = 0;
    c = 1'b0;
    if (i.pc) return;
    case (i.op)
      4'd1:       begin r = (a + b) & 32'hFFFF; c = (a + b) > 32'hFFFF; end
      4'd2, 4'd10: begin r = (a - b) & 32'hFFFF; c = (a < b); end
      4'd3:       r = a & b;
      4'd4:       r = a | b;
      4'd5:       r = a ^ b;
      4'd6:       r = (~a) & 32'hFFFF;
      4'd7:       begin r = (a << sh) & 32'hFFFF; c = (sh != 0) && (((a >> (16 - sh)) & 1) == 1); end
      4'd8:       begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
      4'd9:       begin
        p = longint'(a) * longint'(b);
        r = 32'(p & 64'hFFFF);
        c = (p >> 16) != 0;
      end
      4'd11:      r = b;
      default:    return;
    endcase
    m_z = (r == 0);
    m_c = c;
    m_n = r[15];
    if (i.op != 4'd10) begin
      m_res = r[15:0];
      m_rv  = 1'b1;
      if (i.osel) m_reg[i.rd] = r[15:0];
    end
  endtask

  task automatic drive(input ins_t i);
    OPCODE         = i.op;
    Rreg_Sig1      = i.rs1;
    Rreg_Sig2      = i.rs2;
    Wreg_Sig       = i.rd;
    Immediate_Addr = i.imm;
    Source2_select = i.s2;
    ALU_out_Select = i.osel;
    PC_select      = i.pc;
  endtask

  // Compare outputs and every register (via the debug port) with the model
  task automatic check_state(input string tag);
    chk({tag, ".rv"},  32'(result_valid), 32'(m_rv));
    chk({tag, ".res"}, 32'(result),       32'(m_res));
    chk({tag, ".z"},   32'(flag_z),       32'(m_z));
    chk({tag, ".c"},   32'(flag_c),       32'(m_c));
    chk({tag, ".n"},   32'(flag_n),       32'(m_n));
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      chk($sformatf("%s.R%0d", tag, r), 32'(dbg_data), 32'(m_reg[r]));
    end
  endtask

  // Wait for stall to drop, counting stalled cycles; sampled 1 after each edge
  task automatic wait_stall(input string tag);
    int cnt;
    chk({tag, ".stall_rise"}, 32'(stall), 32'd1);
    cnt = 0;
    while (stall === 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".stall_len"}, 32'(cnt), 32'd16);
  endtask

  task automatic run(input ins_t i, input string tag);
    @(negedge clk);
    drive(i);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (i.op == 4'd9 && !i.pc) wait_stall(tag);
    model_apply(i);
    check_state(tag);
  endtask

  // MUL followed by an instruction that is presented throughout the stall
  task automatic run_mul_held(input ins_t mi, input ins_t ai);
    @(negedge clk);
    drive(mi);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    drive(ai);
    wait_stall("mul_held");
    model_apply(mi);
    check_state("mul_held");
    @(posedge clk); #1;
    instr_valid = 1'b0;
    model_apply(ai);
    check_state("held_add");
  endtask

  initial begin
    ins_t i;
    rstn        = 1'b0;
    instr_valid = 1'b0;
    dbg_addr    = 3'd0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stall", 32'(stall), 32'd0);
    check_state("reset");
    @(negedge clk);
    rstn = 1'b1;

    run(mk(11, 0, 0, 1, 5, 1, 1, 0),  "mov_r1");
    chk("mov_r1.lit", 32'(result), 32'd5);
    run(mk(11, 0, 0, 2, 63, 1, 1, 0), "mov_r2");
    run(mk(6, 0, 0, 1, 0, 0, 1, 0),   "not_r1");
    run(mk(1, 1, 0, 3, 1, 1, 1, 0),   "add_wrap");
    chk("add_wrap.c_lit", 32'(flag_c), 32'd1);
    run(mk(2, 0, 0, 4, 1, 1, 1, 0),   "sub_borrow");
    chk("sub_borrow.lit", 32'(result), 32'hFFFF);
    run(mk(10, 2, 0, 0, 63, 1, 1, 0), "cmp");
    run_mul_held(mk(9, 2, 2, 5, 0, 0, 1, 0), mk(1, 5, 0, 6, 1, 1, 1, 0));
    chk("held_add.lit", 32'(result), 32'd3970);
    run(mk(11, 0, 0, 6, 32, 1, 1, 0), "mov_r6");
    run(mk(7, 6, 0, 6, 3, 1, 1, 0),   "shl_r6");
    run(mk(9, 6, 6, 7, 0, 0, 1, 0),   "mul_ovf");
    chk("mul_ovf.c_lit", 32'(flag_c), 32'd1);
    run(mk(8, 2, 0, 3, 4, 1, 1, 0),   "shr");

    // Reset in the middle of a multiply
    @(negedge clk);
    drive(mk(9, 2, 2, 5, 0, 0, 1, 0));
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.stall", 32'(stall), 32'd0);
    check_state("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_state("post_rst");

    run(mk(11, 0, 0, 1, 7, 1, 1, 0), "mov_r1b");
    run(mk(1, 1, 1, 2, 0, 0, 0, 0),  "add_nowb");
    chk("add_nowb.lit", 32'(result), 32'd14);
    run(mk(1, 1, 1, 2, 0, 0, 1, 1),  "add_pc");

    for (int k = 0; k < 80; k++) begin
      i.op   = 4'($urandom_range(0, 15));
      i.rs1  = 3'($urandom_range(0, 7));
      i.rs2  = 3'($urandom_range(0, 7));
      i.rd   = 3'($urandom_range(0, 7));
      i.imm  = 6'($urandom_range(0, 63));
      i.s2   = 1'($urandom_range(0, 1));
      i.osel = ($urandom_range(0, 3) != 0);
      i.pc   = ($urandom_range(0, 7) == 0);
      run(i, $sformatf("rnd%0d_op%0d", k, i.op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
